// File: rtl/cba_seq.sv
// Byte-serial add/sub sharing one 8-bit carry-bypass cell between two round-robin requesters; CBA_SEQ_SUB_EN enables subtract.
// Latency: rsp_valid rises NBYTES edges after acceptance; requesters are held off (ready low) until the response handshake.
// Backpressure: RESP outputs hold stable while rsp_ready is low.

module cba (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       cin_i,
  output logic [7:0] sum_o,
  output logic       cout_o
);
  logic [7:0] p;
  logic       c;
  logic       c_blk;

  assign p = a_i ^ b_i;

  // Two 4-bit ripple blocks; a fully-propagating block forwards its carry-in directly.
  always_comb begin
    sum_o = '0;
    c     = cin_i;
    c_blk = 1'b0;
    for (int blk = 0; blk < 2; blk++) begin
      c_blk = c;
      for (int i = 0; i < 4; i++) begin
        sum_o[blk*4+i] = p[blk*4+i] ^ c;
        c = (a_i[blk*4+i] & b_i[blk*4+i]) | (c & p[blk*4+i]);
      end
      if (&p[blk*4 +: 4]) c = c_blk;
    end
    cout_o = c;
  end
endmodule

module cba_seq #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [8*NBYTES-1:0] req0_a,
  input  logic [8*NBYTES-1:0] req0_b,
  input  logic                req0_sub,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [8*NBYTES-1:0] req1_a,
  input  logic [8*NBYTES-1:0] req1_b,
  input  logic                req1_sub,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [8*NBYTES-1:0] rsp_sum,
  output logic                rsp_cout,
  output logic                busy
);
  localparam int W = 8 * NBYTES;
  localparam logic [2:0] LAST = 3'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, ADD, RESP} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic           id_q, id_d, fav_q, fav_d, carry_q, carry_d, cout_q, cout_d;
  logic [2:0]     k_q, k_d;
  logic           grant0, grant1;
  logic [7:0]     a_byte, b_byte, b_op, s_byte;
  logic           c_out;

`ifdef CBA_SEQ_SUB_EN
  logic sub_q, sub_d;
  assign b_op = sub_q ? ~b_byte : b_byte;
`else
  logic unused_sub;
  assign unused_sub = req0_sub ^ req1_sub;
  assign b_op       = b_byte;
`endif

  // fav_q = 1 means req1 wins a tie.
  assign grant0 = (state_q == IDLE) && req0_valid && (!req1_valid || !fav_q);
  assign grant1 = (state_q == IDLE) && req1_valid && (!req0_valid ||  fav_q);

  assign req0_ready = grant0 & rst_n;
  assign req1_ready = grant1 & rst_n;
  assign rsp_valid  = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign rsp_id     = id_q;
  assign rsp_sum    = sum_q;
  assign rsp_cout   = cout_q;

  always_comb begin
    a_byte = '0;
    b_byte = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (k_q == 3'(i)) begin
        a_byte = a_q[i*8 +: 8];
        b_byte = b_q[i*8 +: 8];
      end
    end
  end

  cba u_cba (
    .a_i    (a_byte),
    .b_i    (b_op),
    .cin_i  (carry_q),
    .sum_o  (s_byte),
    .cout_o (c_out)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    id_d    = id_q;
    fav_d   = fav_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    k_d     = k_q;
`ifdef CBA_SEQ_SUB_EN
    sub_d   = sub_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          id_d    = grant1;
          a_d     = grant1 ? req1_a : req0_a;
          b_d     = grant1 ? req1_b : req0_b;
          fav_d   = grant0;
          k_d     = '0;
`ifdef CBA_SEQ_SUB_EN
          sub_d   = grant1 ? req1_sub : req0_sub;
          carry_d = sub_d;
`else
          carry_d = 1'b0;
`endif
          state_d = ADD;
        end
      end
      ADD: begin
        for (int i = 0; i < NBYTES; i++) begin
          if (k_q == 3'(i)) sum_d[i*8 +: 8] = s_byte;
        end
        carry_d = c_out;
        k_d     = k_q + 3'd1;
        if (k_q == LAST) begin
          cout_d  = c_out;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      id_q    <= 1'b0;
      fav_q   <= 1'b0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      k_q     <= '0;
`ifdef CBA_SEQ_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      id_q    <= id_d;
      fav_q   <= fav_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      k_q     <= k_d;
`ifdef CBA_SEQ_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end
endmodule

// File: doc/cba_seq.md
CBA_SEQ -- requirements
Module: cba_seq

Interface
REQ-001 SHALL have parameter: NBYTES, 4, operand width in bytes (legal 1..8); W = 8*NBYTES.
REQ-002 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports: req0_valid / req1_valid  input  1  requester i has an operation pending.
REQ-005 SHALL have ports: req0_ready / req1_ready  output  1  requester i is accepted this cycle.
REQ-006 SHALL have ports: req0_a, req0_b / req1_a, req1_b  input  W  operands.
REQ-007 SHALL have ports: req0_sub / req1_sub  input  1  1 = a-b, 0 = a+b.
REQ-008 SHALL have port: rsp_valid  output  1  result available.
REQ-009 SHALL have port: rsp_ready  input  1  consumer takes the result.
REQ-010 SHALL have ports: rsp_id  output  1 (requester index); rsp_sum  output  W; rsp_cout  output  1 (final-byte carry).
REQ-011 SHALL have port: busy  output  1  high in any state other than IDLE.

Function
REQ-012 SHALL time-share exactly one instance of the team's 8-bit carry-bypass adder cell (cba) across all bytes and both requesters.
REQ-013 SHALL implement FSM IDLE -> ADD -> RESP -> IDLE; no other states.
REQ-014 IDLE: drive reqX_ready high only for the arbitration winner among valid requesters; acceptance = valid && ready on a rising edge.
REQ-015 Arbitration SHALL be round-robin: with both valid, grant the favoured requester; after any grant, favour the other requester.
REQ-016 Acceptance edge SHALL capture a, b, sub and id; clear byte counter to 0; load the carry register with 1 for sub, 0 for add; enter ADD.
REQ-017 ADD: each edge SHALL add byte k of a and (b or ~b for sub) with the carry register; write byte k of the result; store cout as the next carry; increment k.
REQ-018 On the edge processing byte NBYTES-1, SHALL enter RESP with rsp_cout = that byte's cout.
REQ-019 rsp_valid SHALL rise exactly NBYTES edges after the acceptance edge.
REQ-020 RESP: rsp_valid, rsp_id, rsp_sum and rsp_cout SHALL hold stable until rsp_valid && rsp_ready; that edge returns the FSM to IDLE.
REQ-021 Both reqX_ready outputs SHALL be low in ADD and RESP; the earliest next acceptance is the edge after the response handshake.
REQ-022 Sub results SHALL be two's complement mod 2^W; rsp_cout = 1 means no borrow.
REQ-023 Request inputs SHALL be ignored outside IDLE; a requester's valid dropping before acceptance SHALL cause no side effect.

Reset
REQ-024 rst_n low SHALL immediately force: state IDLE, rsp_valid 0, rsp_sum 0, rsp_cout 0, rsp_id 0, busy 0, both reqX_ready 0, byte counter 0, carry 0, arbitration favouring req0.
REQ-025 Reset during ADD or RESP SHALL discard the in-flight operation with no response emitted.

Configuration
REQ-026 Macro CBA_SEQ_SUB_EN defined: reqX_sub SHALL be honoured per REQ-016/REQ-017.
REQ-027 Macro CBA_SEQ_SUB_EN undefined: reqX_sub SHALL be ignored; every operation SHALL be an add with carry-in 0; no b-inversion logic is present.

Verification (NBYTES=4)
REQ-028 req0 a=0x000000FF b=0x00000001 add -> rsp_sum 0x00000100, rsp_cout 0, rsp_id 0, rsp_valid 4 edges after acceptance.
REQ-029 a=0xFFFFFFFF b=0x00000001 add -> rsp_sum 0x00000000, rsp_cout 1.
REQ-030 After reset, req0 and req1 both valid continuously -> served req0, req1, req0 in that order.
REQ-031 a=0x00000005 b=0x00000007 sub=1 -> with CBA_SEQ_SUB_EN: 0xFFFFFFFE, cout 0; without it: 0x0000000C, cout 0.
REQ-032 rsp_ready held low 3 cycles in RESP -> outputs stable, both reqX_ready low; handshake on the 4th cycle -> IDLE on the next edge.
REQ-033 rst_n pulsed low during ADD -> all outputs 0 at once; no response; a following request for 0x12345678+0x11111111 returns 0x23456789.
